// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing master driving pixel counters, blanking and registered colour/sync.
// Define VGA_TESTPAT_EN to add the TESTPAT input and the 8-bar test pattern.
module vga_timing_gen #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 800,
  parameter int H_FP    = 56,
  parameter int H_SYNC  = 120,
  parameter int H_BP    = 64,
  parameter int V_VIS   = 600,
  parameter int V_FP    = 37,
  parameter int V_SYNC  = 6,
  parameter int V_BP    = 23,
  parameter int H_POL   = 1,
  parameter int V_POL   = 1
) (
  input  logic        CLK_100MHz,
  input  logic        RESET_N,
  input  logic [3:0]  RED,
  input  logic [3:0]  GREEN,
  input  logic [3:0]  BLUE,
`ifdef VGA_TESTPAT_EN
  input  logic        TESTPAT,
`endif
  output logic [10:0] CurrentX,
  output logic [10:0] CurrentY,
  output logic        HBlank,
  output logic        VBlank,
  output logic        PixelTick,
  output logic        FrameStart,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);
  localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DW       = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_cnt;
  logic [10:0]   h_count, v_count;
  logic [11:0]   pix, rgb;
  logic          h_last, v_last, blank, hs_on, vs_on;
  assign PixelTick  = div_cnt == DW'(CLK_DIV - 1);
  assign h_last     = h_count == 11'(H_TOTAL - 1);
  assign v_last     = v_count == 11'(V_TOTAL - 1);
  assign CurrentX   = h_count;
  assign CurrentY   = v_count;
  assign HBlank     = {1'b0, h_count} >= 12'(H_VIS);
  assign VBlank     = {1'b0, v_count} >= 12'(V_VIS);
  assign blank      = HBlank || VBlank;
  assign FrameStart = PixelTick && h_last && v_last;
  // 12-bit compares so a window ending exactly at 2048 still works
  assign hs_on      = {1'b0, h_count} >= 12'(HS_START) && {1'b0, h_count} < 12'(HS_END);
  assign vs_on      = {1'b0, v_count} >= 12'(VS_START) && {1'b0, v_count} < 12'(VS_END);
  assign {VGA_R, VGA_G, VGA_B} = rgb;
`ifdef VGA_TESTPAT_EN
  logic       tp_en;
  logic [2:0] bar;
  assign bar = 3'(h_count / 11'(H_VIS / 8));
  assign pix = tp_en ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : {RED, GREEN, BLUE};
  // pattern select only changes during blanking so a line is never split
  always_ff @(posedge CLK_100MHz)
    if (!RESET_N) tp_en <= 1'b0;
    else if (blank) tp_en <= TESTPAT;
`else
  assign pix = {RED, GREEN, BLUE};
`endif
  always_ff @(posedge CLK_100MHz) begin
    if (!RESET_N) begin
      div_cnt <= '0;
      h_count <= '0;
      v_count <= '0;
      rgb     <= '0;
      VGA_HS  <= ~1'(H_POL);
      VGA_VS  <= ~1'(V_POL);
    end else begin
      div_cnt <= PixelTick ? '0 : div_cnt + 1'b1;
      if (PixelTick) begin
        h_count <= h_last ? '0 : h_count + 1'b1;
        if (h_last) v_count <= v_last ? '0 : v_count + 1'b1;
        rgb    <= blank ? '0 : pix;
        VGA_HS <= hs_on ? 1'(H_POL) : ~1'(H_POL);
        VGA_VS <= vs_on ? 1'(V_POL) : ~1'(V_POL);
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen on a shrunken raster (24x10 pixels, 2 clocks/pixel).
module tb_vga_timing_gen;
  localparam int CD = 2, HV = 16, HT = 24, VV = 4, VT = 10;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [11:0] col = 12'hfff;
  logic [10:0] cur_x, cur_y;
  logic        hblank, vblank, tick, fstart, hs, vs;
  logic [3:0]  vr, vg, vb;
  int          total = 0, bad = 0, hs_n, vs_n, fs_n;
`ifdef VGA_TESTPAT_EN
  logic        testpat = 1'b0;
`endif
  vga_timing_gen #(
    .CLK_DIV(CD), .H_VIS(HV), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(VV), .V_FP(2), .V_SYNC(2), .V_BP(2), .H_POL(1), .V_POL(1)
  ) dut (
    .CLK_100MHz(clk), .RESET_N(rst_n),
    .RED(col[11:8]), .GREEN(col[7:4]), .BLUE(col[3:0]),
`ifdef VGA_TESTPAT_EN
    .TESTPAT(testpat),
`endif
    .CurrentX(cur_x), .CurrentY(cur_y), .HBlank(hblank), .VBlank(vblank),
    .PixelTick(tick), .FrameStart(fstart),
    .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .VGA_HS(hs), .VGA_VS(vs)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // c counts clocks since the reset state; the output stage shows pixel c/CD-1
  task automatic run(input int n, input bit tp);
    int p, q, x, y, xq, yq, bb, last;
    logic etick, efs, ehs, evs;
    logic [11:0] erg, pat;
    last = -1;
    hs_n = 0;
    vs_n = 0;
    fs_n = 0;
    for (int c = 0; c < n; c++) begin
      p = c / CD;
      q = p - 1;
      x = p % HT;
      y = (p / HT) % VT;
      col = tp ? 12'h000 : 12'(p * 37 + 1);
      etick = (c % CD) == CD - 1;
      efs = etick && x == HT - 1 && y == VT - 1;
      ehs = 1'b0;
      evs = 1'b0;
      erg = 12'h000;
      xq = 0;
      yq = 0;
      if (c >= CD) begin
        xq = q % HT;
        yq = (q / HT) % VT;
        bb = xq / 2;
        pat = {{4{bb[2]}}, {4{bb[1]}}, {4{bb[0]}}};
        ehs = xq >= 18 && xq < 21;
        evs = yq >= 6 && yq < 8;
        if (xq < HV && yq < VV) erg = tp ? (q >= HT ? pat : 12'h000) : 12'(q * 37 + 1);
      end
      check($sformatf("cyc%0d", c),
            {cur_x, cur_y, tick, fstart, hblank, vblank, hs, vs, vr, vg, vb},
            {11'(x), 11'(y), etick, efs, x >= HV, y >= VV, ehs, evs, erg});
      if (fstart) begin
        fs_n++;
        if (last >= 0) check("fs_period", c - last, HT * VT * CD);
        last = c;
      end
      if (c >= CD && c < CD + HT * VT * CD) begin
        hs_n += int'(hs);
        vs_n += int'(vs);
      end
      if (tp && c >= CD && q >= HT && yq < VV) begin
        if (xq == 0) check("tp_bar0", {vr, vg, vb}, 12'h000);
        if (xq == 2) check("tp_bar1", {vr, vg, vb}, 12'h00f);
        if (xq == 14) check("tp_bar7", {vr, vg, vb}, 12'hfff);
      end
      step();
    end
  endtask
  initial begin
    repeat (5) step();
    check("rst_rgb", {vr, vg, vb}, 12'h000);
    check("rst_hs", hs, 1'b0);
    check("rst_vs", vs, 1'b0);
    check("rst_x", cur_x, 11'd0);
    check("rst_y", cur_y, 11'd0);
    check("rst_tick", tick, 1'b0);
    rst_n = 1'b1;
    run(2 * HT * VT * CD, 1'b0);
    check("hs_cycles", hs_n, 60);
    check("vs_cycles", vs_n, 96);
    check("fs_count", fs_n, 2);
    col = 12'h5a3;
    for (int i = 0; i < 2000 && !(cur_x == 11'd8 && cur_y == 11'd2); i++) step();
    check("seek", {cur_x, cur_y}, {11'd8, 11'd2});
    check("mask_vis", {vr, vg, vb}, 12'h5a3);
    rst_n = 1'b0;
    step();
    check("mid_x", cur_x, 11'd0);
    check("mid_y", cur_y, 11'd0);
    check("mid_tick", tick, 1'b0);
    check("mid_rgb", {vr, vg, vb}, 12'h000);
    check("mid_hs", hs, 1'b0);
    check("mid_vs", vs, 1'b0);
    rst_n = 1'b1;
    run(HT * VT * CD, 1'b0);
`ifdef VGA_TESTPAT_EN
    rst_n = 1'b0;
    testpat = 1'b1;
    step();
    rst_n = 1'b1;
    run(HT * VT * CD, 1'b1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
